// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the bit-serial arithmetic blocks.
//   state_e        : control FSM states (IDLE, SHIFT, DONE)
//   cnt_width()    : bit counter width for a given operand width
//   sub_diff()     : one-bit full-subtractor difference
//   sub_borrow()   : one-bit full-subtractor borrow-out
// -----------------------------------------------------------------------------
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // The counter only has to reach width-1, so $clog2(width) bits suffice.
   // The guard keeps a one-bit counter for degenerate widths.
   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   // d = x - y - bin (mod 2)
   function automatic logic sub_diff(input logic x, input logic y, input logic bin);
      return x ^ y ^ bin;
   endfunction

   // Borrow out: x < y, or x == y with an incoming borrow.
   function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
      return (~x & y) | (~(x ^ y) & bin);
   endfunction

endpackage

// File: rtl/sub_cell.sv
// -----------------------------------------------------------------------------
// sub_cell
// Combinational one-bit full subtractor: {bo, d} = x - y - bin.
// Ports:
//   x   in  minuend bit
//   y   in  subtrahend bit
//   bin in  borrow in
//   d   out difference bit
//   bo  out borrow out
// -----------------------------------------------------------------------------
module sub_cell
   import arith_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = sub_diff(x, y, bin);
   assign bo = sub_borrow(x, y, bin);

endmodule

// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
// Bit-serial subtractor computing a - b, one bit per clock, LSB first, through
// a single sub_cell and a borrow flop. A start/done handshake launches an
// operation and presents diff/bout/ovf for collection.
//
// Handshake: start is sampled on rising clk and accepted only in IDLE or DONE
// (ignored while busy). a and b are captured on the accepting edge. done is a
// one-cycle pulse WIDTH cycles after the accepting edge; diff/bout/ovf update
// only on that edge and hold until the next completion.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   launch request
//   a, b      in   minuend / subtrahend (WIDTH bits)
//   busy      out  high while shifting
//   done      out  one-cycle completion pulse
//   diff      out  a - b mod 2^WIDTH
//   bout      out  final borrow (a < b unsigned)
//   ovf       out  signed overflow of a - b
//   dbg_state out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module serial_sub
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output state_e           dbg_state
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic             br_q, br_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   // FSM-derived controls
   logic accept;
   logic shift_en;
   logic last;

   // Subtractor cell outputs
   logic cell_d;
   logic cell_bo;

   sub_cell u_sub_cell (
      .x   (ra_q[0]),
      .y   (rb_q[0]),
      .bin (br_q),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_SHIFT;
         ST_SHIFT: if (cnt_q == CNT_LAST) state_d = ST_DONE;
         ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and datapath controls
   // ---------------------------------------------------------------------------
   always_comb begin
      accept   = 1'b0;
      shift_en = 1'b0;
      last     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            accept = start;
         end
         ST_SHIFT: begin
            busy     = 1'b1;
            shift_en = 1'b1;
            last     = (cnt_q == CNT_LAST);
         end
         ST_DONE: begin
            done   = 1'b1;
            accept = start;
         end
         default: begin
            accept = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      cnt_d   = cnt_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rd_d    = rd_q;
      br_d    = br_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;

      if (accept) begin
         ra_d    = a;
         rb_d    = b;
         rd_d    = '0;
         br_d    = 1'b0;
         cnt_d   = '0;
         a_msb_d = a[WIDTH-1];
         b_msb_d = b[WIDTH-1];
      end else if (shift_en) begin
         ra_d  = {1'b0, ra_q[WIDTH-1:1]};
         rb_d  = {1'b0, rb_q[WIDTH-1:1]};
         rd_d  = {cell_d, rd_q[WIDTH-1:1]};
         br_d  = cell_bo;
         cnt_d = cnt_q + CW'(1);
      end

      // Results are taken from the cell directly on the final bit so that the
      // last difference/borrow bit is included without an extra cycle.
      if (last) begin
         diff_d = {cell_d, rd_q[WIDTH-1:1]};
         bout_d = cell_bo;
         // Overflow only possible when operand signs differ; it occurred if the
         // result sign differs from the minuend sign.
         ovf_d  = (a_msb_q != b_msb_q) & (cell_d != a_msb_q);
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rd_q    <= '0;
         br_q    <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rd_q    <= rd_d;
         br_q    <= br_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign diff      = diff_q;
   assign bout      = bout_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
   import arith_pkg::*;

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, bout8, ovf8;
   logic [7:0] diff8;
   state_e     state8;

   // WIDTH=3 instance
   logic       start3 = 1'b0;
   logic [2:0] a3 = '0, b3 = '0;
   logic       busy3, done3, bout3, ovf3;
   logic [2:0] diff3;
   state_e     state3;

   serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8),
      .dbg_state(state8)
   );

   serial_sub #(.WIDTH(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3),
      .dbg_state(state3)
   );

   int vectors = 0;
   int miscompares = 0;

   // ---------------------------------------------------------------------------
   // Reference model: plain integer arithmetic on w-bit operands
   // ---------------------------------------------------------------------------
   function automatic void ref_sub(input int av, input int bv, input int w,
                                   output int d, output bit bo, output bit ov);
      int m, sa, sb, r;
      m  = 1 << w;
      d  = ((av - bv) % m + m) % m;
      bo = (av < bv);
      sa = (av >= m / 2) ? av - m : av;
      sb = (bv >= m / 2) ? bv - m : bv;
      r  = sa - sb;
      ov = (r < -(m / 2)) || (r > (m / 2 - 1));
   endfunction

   // ---------------------------------------------------------------------------
   // Driver / checker tasks
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One WIDTH=8 operation with latency/busy checks. With noisy set, start/a/b
   // are scrambled while shifting.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit noisy,
                      input string tag);
      int d, edges, busy_n;
      bit bo, ov;
      ref_sub(int'(av), int'(bv), 8, d, bo, ov);
      start8 = 1'b1; a8 = av; b8 = bv;
      tick();
      start8 = 1'b0;
      edges = 0; busy_n = 0;
      while (!done8 && edges < 30) begin
         if (busy8) busy_n++;
         if (noisy) begin
            start8 = 1'($urandom_range(0, 1));
            a8     = 8'($urandom);
            b8     = 8'($urandom);
         end
         tick();
         edges++;
      end
      start8 = 1'b0;
      check({tag, "_latency"}, edges, 8);
      check({tag, "_busy_cycles"}, busy_n, 8);
      check({tag, "_diff"}, {24'd0, diff8}, d);
      check({tag, "_bout"}, {31'd0, bout8}, {31'd0, bo});
      check({tag, "_ovf"}, {31'd0, ovf8}, {31'd0, ov});
      tick();
      check({tag, "_done_pulse"}, {31'd0, done8}, 0);
      check({tag, "_idle_after"}, {31'd0, busy8}, 0);
   endtask

   task automatic op3(input int av, input int bv);
      int d, edges;
      bit bo, ov;
      ref_sub(av, bv, 3, d, bo, ov);
      start3 = 1'b1; a3 = 3'(av); b3 = 3'(bv);
      tick();
      start3 = 1'b0;
      edges = 0;
      while (!done3 && edges < 20) begin
         tick();
         edges++;
      end
      check($sformatf("w3_%0d_%0d_latency", av, bv), edges, 3);
      check($sformatf("w3_%0d_%0d_diff", av, bv), {29'd0, diff3}, d);
      check($sformatf("w3_%0d_%0d_bout", av, bv), {31'd0, bout3}, {31'd0, bo});
      check($sformatf("w3_%0d_%0d_ovf", av, bv), {31'd0, ovf3}, {31'd0, ov});
      tick();
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // ---------------------------------------------------------------------------
   // Directed and random sequence
   // ---------------------------------------------------------------------------
   initial begin
      int edges, gap, done_seen;

      // Reset state
      #12;
      check("rst_busy", {31'd0, busy8}, 0);
      check("rst_done", {31'd0, done8}, 0);
      check("rst_diff", {24'd0, diff8}, 0);
      check("rst_bout", {31'd0, bout8}, 0);
      check("rst_ovf", {31'd0, ovf8}, 0);
      check("rst_state", {30'd0, state8}, {30'd0, ST_IDLE});
      rst_n = 1'b1;
      tick();

      // Basic operations
      op8(8'd100, 8'd58, 1'b0, "s100_58");
      check("s100_58_const", {24'd0, diff8}, 42);
      op8(8'd5, 8'd7, 1'b0, "s5_7");
      check("s5_7_const", {24'd0, diff8}, 32'hFE);
      op8(8'h80, 8'h01, 1'b0, "s80_01");
      check("s80_01_ovf_const", {31'd0, ovf8}, 1);

      // Start and operand noise during SHIFT
      op8(8'h3C, 8'h0F, 1'b1, "noisy_3c_0f");
      check("noisy_const", {24'd0, diff8}, 32'h2D);

      // Back-to-back with start held high
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      tick();
      a8 = 8'h00; b8 = 8'h01;
      edges = 0;
      while (!done8 && edges < 30) begin tick(); edges++; end
      check("b2b_first_latency", edges, 8);
      check("b2b_first_diff", {24'd0, diff8}, 0);
      check("b2b_first_bout", {31'd0, bout8}, 0);
      gap = 0;
      tick(); gap++;
      check("b2b_restart_busy", {31'd0, busy8}, 1);
      while (!done8 && gap < 30) begin tick(); gap++; end
      start8 = 1'b0;
      check("b2b_gap", gap, 9);
      check("b2b_second_diff", {24'd0, diff8}, 32'hFF);
      check("b2b_second_bout", {31'd0, bout8}, 1);
      tick();
      check("b2b_end_idle", {30'd0, state8}, {30'd0, ST_IDLE});

      // Asynchronous reset in the 4th SHIFT cycle
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      check("abort_busy_before", {31'd0, busy8}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy8}, 0);
      check("abort_done", {31'd0, done8}, 0);
      check("abort_diff", {24'd0, diff8}, 0);
      check("abort_bout", {31'd0, bout8}, 0);
      check("abort_ovf", {31'd0, ovf8}, 0);
      #3 rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done8) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      op8(8'd20, 8'd3, 1'b0, "s20_3");
      check("s20_3_const", {24'd0, diff8}, 17);

      // Randomized operations
      for (int i = 0; i < 24; i++) begin
         op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             $sformatf("rand%0d", i));
      end

      // Exhaustive WIDTH=3
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) begin
            op3(x, y);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned/two's-complement subtractor. It computes `a - b` one bit per clock, LSB first, using a single one-bit full-subtractor cell and a borrow flip-flop. It is the subtract-direction companion to the team's one-bit full-adder arithmetic, and serves as the low-area subtract path for datapaths where latency is cheap and gates are not. A start/done handshake lets a controller launch an operation and collect `diff`, `bout` and `ovf` when the operation finishes.

## Interface
- `WIDTH`, 8, operand and result width in bits (≥2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  launch request; sampled on rising `clk`
- `a`  in  WIDTH  minuend; captured on accepted start
- `b`  in  WIDTH  subtrahend; captured on accepted start
- `busy`  out  1  high while the state is SHIFT
- `done`  out  1  one-cycle pulse; results valid
- `diff`  out  WIDTH  `a - b` mod 2^WIDTH
- `bout`  out  1  final borrow; 1 iff `a < b` unsigned
- `ovf`  out  1  signed overflow of `a - b`

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if `start`=1, go to SHIFT.
  - SHIFT: when the bit counter reaches WIDTH-1, go to DONE.
  - DONE: if `start`=1, go to SHIFT; otherwise go to IDLE.
- Accepted start (in IDLE or DONE):
  - Load shift registers `ra`←`a` and `rb`←`b`.
  - Clear borrow register `br`←0 and counter `cnt`←0.
  - Latch `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow calculation.
- Each SHIFT cycle:
  - `d = ra[0] ^ rb[0] ^ br`
  - `bo = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br)`
  - `br`←`bo`
  - `ra` and `rb` shift right by 1.
  - `d` shifts into the MSB of the internal result register `rd`, which shifts right.
  - `cnt`++
- On the edge that enters DONE:
  - `diff`←the final `rd`, including the last `d`.
  - `bout`←the final `bo`.
  - `ovf`←`(a_msb != b_msb) & (d_msb != a_msb)`.
- `diff`, `bout` and `ovf` change only on the edge that enters DONE. They hold through IDLE and through any later SHIFT, until the next completion.
- `start` while in SHIFT is ignored. Changes to `a` and `b` after acceptance have no effect.
- Reset, at any time including mid-SHIFT:
  - State→IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0.
  - All internal registers cleared.
  - The aborted operation never produces `done`.
- Arithmetic is purely modular and there is no saturation. `bout` and `ovf` are independent flags; the consumer chooses the unsigned or signed interpretation.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE or DONE.
  - SHIFT is active for the WIDTH edges E1..E_WIDTH.
  - `busy`=1 for WIDTH cycles, from after E0 until E_WIDTH.
  - `done`=1 for exactly the one cycle between E_WIDTH and E_WIDTH+1.
- Latency from the start edge to `done` high is WIDTH cycles.
- Back-to-back throughput is one operation per WIDTH+1 cycles when `start` is held high. The start in the DONE cycle is accepted at E_WIDTH+1.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- A shared package `arith_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE)
  - the counter-width function `$clog2(WIDTH)`
  - the one-bit subtract equations, as constants/functions reused by future serial arithmetic blocks.
- Sub-module `sub_cell`: combinational one-bit full subtractor with ports (`x`, `y`, `bin`, `d`, `bo`), instantiated once.
- The top level contains the FSM, counter, shift registers and output registers.

## Test plan
All scenarios use WIDTH=8 except the exhaustive sweep.
- `a`=100, `b`=58, pulse `start` → `diff`=42, `bout`=0, `ovf`=0; `done` high exactly 8 cycles after the start edge, for 1 cycle; `busy` high 8 cycles.
- `a`=5, `b`=7 → `diff`=8'hFE, `bout`=1, `ovf`=0. Then `a`=8'h80, `b`=8'h01 → `diff`=8'h7F, `bout`=0, `ovf`=1.
- Assert `start` and toggle `a`/`b` randomly during SHIFT of a 8'h3C−8'h0F operation → extra starts ignored; result 8'h2D, `bout`=0; one `done` only.
- Hold `start`=1 continuously with `a`=8'hFF, `b`=8'hFF then `a`=0, `b`=1 → second operation accepted in the DONE cycle. Results: `diff`=0, `bout`=0, then `diff`=8'hFF, `bout`=1. `done` pulses are 9 cycles apart.
- Assert `rst_n`=0 at the 4th SHIFT cycle → all outputs 0 immediately (asynchronously) and no `done`. A following start with 20−3 yields 17.
- WIDTH=3, exhaustive: all 64 (`a`,`b`) pairs → `diff`, `bout` and `ovf` match a reference model.
